muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting in the execute stage beside the single-cycle ALU. It accepts one operation at a time from the decode/ALU-control path. It runs an iterative 32-step shift-add multiply or restoring divide, asserts `busy_o` so the pipeline stalls, and presents a registered 32-bit result with a one-cycle `done_o` pulse.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock, all state updates on rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `start_i`  in  1  request a new operation; sampled only in IDLE.
- `funct3_i`  in  3  M-extension funct3, sampled with `start_i`.
- `op_a_i`  in  XLEN  rs1 value (multiplicand / dividend).
- `op_b_i`  in  XLEN  rs2 value (multiplier / divisor).
- `flush_i`  in  1  abort the current operation (pipeline flush).
- `busy_o`  out  1  high whenever state is not IDLE.
- `done_o`  out  1  high for exactly one cycle, in state DONE.
- `result_o`  out  XLEN  registered result, held until the next DONE.

## Operation
- funct3 map:
  - 000 MUL: low 32 bits.
  - 001 MULH: signed×signed, high 32 bits.
  - 010 MULHSU: signed×unsigned, high 32 bits.
  - 011 MULHU: unsigned×unsigned, high 32 bits.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if `start_i` and not `flush_i`, latch funct3 and operands, then go to PREP.
- PREP: take operand magnitudes per signedness and record the result sign.
  - Multiply result sign = sign(a) XOR sign(b), over the signed operands only.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Clear the 64-bit accumulator, set iteration counter = 0, go to CALC.
  - Special cases load `result_o` directly and go to DONE, skipping CALC and FIX:
    - Divide by zero (b=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
    - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle, 5-bit counter; go to FIX after iteration 31.
  - Multiply: shift-add on a 64-bit product register.
  - Divide: restoring shift-subtract on a 32-bit remainder plus a 32-bit quotient register.
- FIX: apply two's-complement negation per the recorded sign, select low/high half or quotient/remainder, write `result_o`, go to DONE.
- DONE: `done_o`=1, then unconditionally return to IDLE. `start_i` is ignored in DONE.
- Flush:
  - `flush_i` in any state forces IDLE at the next edge.
  - No `done_o` is produced and `result_o` is unchanged.
  - `flush_i` and `start_i` together in IDLE: flush wins and nothing is latched.
- `start_i` outside IDLE is ignored; it is not queued.
- Arithmetic: all internal magnitudes are unsigned XLEN. Negating 0x80000000 yields 0x80000000 (wraps).

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, all internal registers 0.
- Reset mid-operation returns to IDLE immediately and asynchronously, with no `done_o`.
- Normal latency, with `start_i` sampled at edge 0:
  - PREP in cycle 1, CALC in cycles 2–33, FIX in cycle 34.
  - DONE (`done_o`=1, `result_o` valid) in cycle 35.
- Special-case latency: PREP in cycle 1, DONE in cycle 2.
- `busy_o` rises in cycle 1 and stays high through DONE inclusive. It falls in the cycle after DONE, when a new `start_i` may be accepted.
- `done_o` and `busy_o` decode combinationally from the state register only. `result_o` is a flop.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `done_o` in cycle 35, `result_o`=0xFFFFFFEB; `busy_o` high cycles 1–35.
- MULH a=b=0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → quotient 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- DIVU b=0, a=0x1234 → `done_o` in cycle 2, result 0xFFFFFFFF. REM a=0x80000000, b=0xFFFFFFFF → result 0 in cycle 2.
- `flush_i` pulsed in cycle 10 of a MUL → IDLE at cycle 11, no `done_o`, `result_o` keeps its prior value. A new start at cycle 11 completes normally in cycle 46.
- `rst_i` asserted mid-CALC → outputs reset immediately. `start_i` held through DONE → only the first request executes, with one `done_o` pulse.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Shift-add multiply and restoring divide, one step per cycle.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_ma;
    logic [XLEN-1:0]   r_mb;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [4:0]        r_cnt;
    logic              r_neg;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_fix_res;

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;

    // Operand signedness, magnitudes and special-case detection
    always_comb begin
        w_is_div = r_funct3[2];
        if (w_is_div) begin
            w_a_sgn = r_a[XLEN-1] & ~r_funct3[0];
            w_b_sgn = r_b[XLEN-1] & ~r_funct3[0];
        end else begin
            w_a_sgn = r_a[XLEN-1] & (r_funct3[1:0] == 2'b01 ||
                                     r_funct3[1:0] == 2'b10);
            w_b_sgn = r_b[XLEN-1] & (r_funct3[1:0] == 2'b01);
        end
        w_mag_a    = w_a_sgn ? -r_a : r_a;
        w_mag_b    = w_b_sgn ? -r_b : r_b;
        w_div_zero = w_is_div && (r_b == '0);
        w_ovf      = w_is_div && !r_funct3[0] &&
                     (r_a == MIN_NEG) && (r_b == '1);
        if (w_div_zero)
            w_special = r_funct3[1] ? r_a : '1;
        else
            w_special = r_funct3[1] ? '0 : MIN_NEG;
    end

    // One multiply or divide iteration, plus final sign fix-up
    always_comb begin
        w_addend  = r_mb[0] ? r_ma : '0;
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, r_mb});
        w_diff    = w_shift[XLEN-1:0] - r_mb;
        w_prod    = r_neg ? -r_acc : r_acc;
        w_q       = r_neg ? -r_quo : r_quo;
        w_r       = r_neg_rem ? -r_rem : r_rem;
        w_fix_res = '0;
        case (r_funct3)
            3'b000:  w_fix_res = w_prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  w_fix_res = w_q;
            default: w_fix_res = w_r;
        endcase
    end

    // Sequencer state machine and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_funct3  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_funct3 <= funct3_i;
                        r_a      <= op_a_i;
                        r_b      <= op_b_i;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_ma      <= w_mag_a;
                    r_mb      <= w_mag_b;
                    r_neg     <= w_a_sgn ^ w_b_sgn;
                    r_neg_rem <= w_a_sgn;
                    r_acc     <= '0;
                    r_rem     <= '0;
                    r_quo     <= w_mag_a;
                    r_cnt     <= '0;
                    if (w_div_zero || w_ovf) begin
                        r_result <= w_special;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_is_div) begin
                        r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                        r_mb  <= r_mb >> 1;
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq
// against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) &&
            a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 35;
    endfunction

    // Issue one op (start sampled at edge 0), observe until done_o
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit hold,
                          output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit idle_after);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        lat = -1; busy_ok = 1'b1; res = 'x; idle_after = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c; res = result;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        idle_after = !busy && !done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done);
        end
        compared++;
        if (result !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_result: got %h required 0", result);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  tf3 [10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4,
                                  3'd6, 3'd5, 3'd7, 3'd5, 3'd6};
        logic [31:0] ta  [10] = '{32'd7, 32'h80000000, 32'h80000000,
                                  32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'h1234, 32'h80000000};
        logic [31:0] tb  [10] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000,
                                  32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'hFFFFFFFF};
        logic [31:0] te  [10] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000,
                                  32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'd14, 32'd2, 32'hFFFFFFFF, 32'd0};
        int          tl  [10] = '{35, 35, 35, 35, 35, 35, 35, 35, 2, 2};
        logic [31:0] res;
        int          lat;
        bit          bok;
        bit          idl;
        for (int i = 0; i < 10; i++) begin
            run_op(tf3[i], ta[i], tb[i], 1'b0, res, lat, bok, idl);
            compared++;
            if (res !== te[i]) begin
                mismatched++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, te[i]);
            end
            compared++;
            if (lat != tl[i]) begin
                mismatched++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, tl[i]);
            end
            compared++;
            if (!bok || !idl) begin
                mismatched++;
                $display("FAIL directed_busy[%0d]: busy_held=%b idle_after=%b required 1 1", i, bok, idl);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        bit          bok;
        bit          idl;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            exp = ref_model(f3, a, b);
            run_op(f3, a, b, 1'b0, res, lat, bok, idl);
            compared++;
            if (res !== exp) begin
                mismatched++;
                $display("FAIL random_result f3=%0d a=%h b=%h: got %h required %h", f3, a, b, res, exp);
            end
            compared++;
            if (lat != ref_latency(f3, a, b) || !bok || !idl) begin
                mismatched++;
                $display("FAIL random_timing f3=%0d: lat=%0d busy_held=%b idle_after=%b required %0d 1 1",
                         f3, lat, bok, idl, ref_latency(f3, a, b));
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [31:0] prev;
        int          lat;
        int          dcnt;
        bit          bok;
        bit          idl;
        run_op(3'd5, 32'd100, 32'd7, 1'b0, prev, lat, bok, idl);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        compared++;
        if (busy !== 1'b0 || result !== prev) begin
            mismatched++;
            $display("FAIL flush_abort: busy=%b result=%h required 0 %h", busy, result, prev);
        end
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        compared++;
        if (dcnt != 0 || result !== prev) begin
            mismatched++;
            $display("FAIL flush_no_done: done_pulses=%0d result=%h required 0 %h", dcnt, result, prev);
        end
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_beats_start: busy=%b required 0", busy);
        end
        run_op(3'd0, 32'd12345, 32'd678, 1'b0, res, lat, bok, idl);
        compared++;
        if (res !== 32'd8369910 || lat != 35) begin
            mismatched++;
            $display("FAIL flush_restart: result=%h lat=%0d required %h 35", res, lat, 32'd8369910);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1; op_a = 32'h7; op_b = 32'h9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                compared++;
                mismatched++;
                $display("FAIL reset_mid_done: got done=1 required 0");
            end
        end
    endtask

    task automatic test_start_held;
        logic [31:0] res;
        int          lat;
        int          dcnt;
        bit          bok;
        bit          idl;
        run_op(3'd4, 32'd1000, 32'hFFFFFFF6, 1'b1, res, lat, bok, idl);
        compared++;
        if (res !== 32'hFFFFFF9C || lat != 35 || !idl) begin
            mismatched++;
            $display("FAIL start_held: result=%h lat=%0d idle_after=%b required ffffff9c 35 1", res, lat, idl);
        end
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        compared++;
        if (dcnt != 0) begin
            mismatched++;
            $display("FAIL start_held_single: extra active cycles=%0d required 0", dcnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
